edge_generator: RTL and testbench

EDGE_GENERATOR -- requirements
Module: edge_generator

---
 rtl/edge_gen_pkg.sv | 18 +
 rtl/edge_generator_phase_counter.sv | 36 +++
 rtl/edge_generator.sv | 174 +++++++++++++++++
 tb/tb_edge_generator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_gen_pkg.sv
// Shared definitions for the edge generator: state encoding and default widths.
package edge_gen_pkg;

  localparam int DEFAULT_CNT_W = 16;
  localparam int DEFAULT_NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Length-minus-one reload value for a phase; zero-length phases collapse to one cycle.
  function automatic logic [63:0] phase_reload(input logic [63:0] len);
    return (len == 64'd0) ? 64'd0 : len - 64'd1;
  endfunction

endpackage

// File: rtl/edge_generator_phase_counter.sv
// Phase down-counter: loads a cycle count, decrements to zero and saturates there.
module phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over decrement, and the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/edge_generator.sv
// Pulse-train generator with registered waveform, edge strobes, busy and done.
// Optional feature: define EDGE_GENERATOR_ABORT_EN to add the abort input.
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int NUM_W = DEFAULT_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef EDGE_GENERATOR_ABORT_EN
  input  logic             abort,
`endif
  input  logic [CNT_W-1:0] highCycles,
  input  logic [CNT_W-1:0] lowCycles,
  input  logic [NUM_W-1:0] pulseCount,
  output logic             signalOut,
  output logic             risingEdge,
  output logic             fallingEdge,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             signal_q, signal_d;
  logic             rising_q, rising_d;
  logic             falling_q, falling_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [NUM_W-1:0] remaining_q, remaining_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] high_reload;
  logic [CNT_W-1:0] low_reload;

  // The phase counter holds "cycles left minus one" so an all-ones length still fits.
  assign high_reload = CNT_W'(phase_reload(64'(high_len_q)));
  assign low_reload  = CNT_W'(phase_reload(64'(low_len_q)));

  phase_counter #(
    .W(CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and next-output decode; edge strobes are derived from phase changes.
  always_comb begin
    state_d     = state_q;
    signal_d    = signal_q;
    rising_d    = 1'b0;
    falling_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    remaining_d = remaining_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_val     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          high_len_d  = highCycles;
          low_len_d   = lowCycles;
          remaining_d = pulseCount;
          if ((pulseCount == '0) || (highCycles == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d  = HIGH;
            signal_d = 1'b1;
            rising_d = 1'b1;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = highCycles - 1'b1;
          end
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          state_d   = LOW;
          signal_d  = 1'b0;
          falling_d = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = low_reload;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          if (remaining_q <= NUM_W'(1)) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            remaining_d = '0;
          end else begin
            state_d     = HIGH;
            signal_d    = 1'b1;
            rising_d    = 1'b1;
            remaining_d = remaining_q - 1'b1;
            cnt_load    = 1'b1;
            cnt_val     = high_reload;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

`ifdef EDGE_GENERATOR_ABORT_EN
    // Abort drops the waveform at once and still reports completion.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      signal_d    = 1'b0;
      rising_d    = 1'b0;
      falling_d   = signal_q;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      remaining_d = '0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
    end
`endif
  end

  // State and registered outputs, all cleared synchronously by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      signal_q    <= 1'b0;
      rising_q    <= 1'b0;
      falling_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      signal_q    <= signal_d;
      rising_q    <= rising_d;
      falling_q   <= falling_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      remaining_q <= remaining_d;
    end
  end

  assign signalOut   = signal_q;
  assign risingEdge  = rising_q;
  assign fallingEdge = falling_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator: directed scenarios plus random trains
// checked every cycle against a schedule-based model (train start, period, end cycle).
`timescale 1ns/1ps
module tb_edge_generator;

  localparam int CW = 4;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] highCycles = '0;
  logic [CW-1:0] lowCycles = '0;
  logic [NW-1:0] pulseCount = '0;
  logic          signalOut, risingEdge, fallingEdge, busy, done;
  logic          abort_eff;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit checking = 1'b0;
  int b = 0;

  // expected outputs for the current cycle
  bit e_sig, e_rise, e_fall, e_busy, e_done;
  // model of the running train
  bit m_active = 1'b0;
  int m_t0, m_end, m_H, m_P;

  always #5 clk = ~clk;

`ifdef EDGE_GENERATOR_ABORT_EN
  assign abort_eff = abort;
`else
  assign abort_eff = 1'b0;
`endif

  edge_generator #(.CNT_W(CW), .NUM_W(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef EDGE_GENERATOR_ABORT_EN
    .abort       (abort),
`endif
    .highCycles  (highCycles),
    .lowCycles   (lowCycles),
    .pulseCount  (pulseCount),
    .signalOut   (signalOut),
    .risingEdge  (risingEdge),
    .fallingEdge (fallingEdge),
    .busy        (busy),
    .done        (done)
  );

  // Model: on each edge, decide what the next cycle must show from the train schedule.
  initial begin
    int c, off, lp;
    bit n_sig, n_rise, n_fall, n_busy, n_done;
    e_sig = 0; e_rise = 0; e_fall = 0; e_busy = 0; e_done = 0;
    forever begin
      @(posedge clk);
      c = cyc + 1;
      n_sig = 0; n_rise = 0; n_fall = 0; n_busy = 0; n_done = 0;
      if (reset) begin
        m_active = 0;
      end else if (abort_eff && e_busy) begin
        m_active = 0;
        n_fall = e_sig;
        n_done = 1;
      end else begin
        if (start && !e_busy) begin
          if (pulseCount == 0 || highCycles == 0) begin
            m_active = 0;
            n_done = 1;
          end else begin
            lp = (lowCycles == 0) ? 1 : int'(lowCycles);
            m_active = 1;
            m_t0 = c;
            m_H = int'(highCycles);
            m_P = m_H + lp;
            m_end = m_t0 + int'(pulseCount) * m_P;
          end
        end
        if (m_active && c >= m_t0 && c < m_end) begin
          off = (c - m_t0) % m_P;
          n_sig = (off < m_H);
          n_rise = (off == 0);
          n_fall = (off == m_H);
          n_busy = 1;
        end
        if (m_active && c == m_end) n_done = 1;
      end
      e_sig = n_sig; e_rise = n_rise; e_fall = n_fall; e_busy = n_busy; e_done = n_done;
      cyc = c;
    end
  end

  task automatic check1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check1("signalOut", signalOut, e_sig);
        check1("risingEdge", risingEdge, e_rise);
        check1("fallingEdge", fallingEdge, e_fall);
        check1("busy", busy, e_busy);
        check1("done", done, e_done);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: cycle %0d reached time limit, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic go_to(int c);
    if (cyc > c) begin
      fails++;
      $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, c);
    end
    while (cyc < c) @(negedge clk);
  endtask

  // Literal expectation: {signalOut,risingEdge,fallingEdge,busy,done} at cycle c.
  task automatic expect_at(int c, logic [4:0] v, string name);
    go_to(c);
    tests++;
    if ({signalOut, risingEdge, fallingEdge, busy, done} !== v) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc,
               {signalOut, risingEdge, fallingEdge, busy, done}, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; abort = 0;
    go_to(cyc + 2);
    reset = 0;
    b = cyc;
  endtask

  task automatic pulse_start(int c, int h, int l, int n);
    go_to(c);
    start = 1;
    highCycles = CW'(h); lowCycles = CW'(l); pulseCount = NW'(n);
    $display("[TB] cycle %0d start H=%0d L=%0d N=%0d", c - b, h, l, n);
    go_to(c + 1);
    start = 0;
  endtask

  initial begin
    int nstarts;
    do_reset();
    checking = 1;
    expect_at(cyc, 5'b00000, "reset_state");

    // basic two-pulse train
    do_reset();
    pulse_start(b + 10, 3, 2, 2);
    expect_at(b + 11, 5'b11010, "s1_rise1");
    expect_at(b + 13, 5'b10010, "s1_high_end");
    expect_at(b + 14, 5'b00110, "s1_fall1");
    expect_at(b + 16, 5'b11010, "s1_rise2");
    expect_at(b + 19, 5'b00110, "s1_fall2");
    expect_at(b + 20, 5'b00010, "s1_last_low");
    expect_at(b + 21, 5'b00001, "s1_done");
    expect_at(b + 22, 5'b00000, "s1_idle");

    // start ignored while busy, accepted in the done cycle
    do_reset();
    pulse_start(b + 10, 3, 2, 2);
    pulse_start(b + 12, 1, 0, 1);
    expect_at(b + 14, 5'b00110, "s2_fall1");
    pulse_start(b + 15, 5, 5, 3);
    expect_at(b + 16, 5'b11010, "s2_rise2");
    expect_at(b + 19, 5'b00110, "s2_fall2");
    expect_at(b + 21, 5'b00001, "s2_done");
    pulse_start(b + 21, 2, 1, 1);
    expect_at(b + 22, 5'b11010, "s2_restart_rise");
    expect_at(b + 24, 5'b00110, "s2_restart_fall");
    expect_at(b + 25, 5'b00001, "s2_restart_done");

    // degenerate starts
    do_reset();
    pulse_start(b + 5, 3, 2, 0);
    expect_at(b + 6, 5'b00001, "s3_n0_done");
    expect_at(b + 7, 5'b00000, "s3_n0_idle");
    do_reset();
    pulse_start(b + 5, 0, 2, 2);
    expect_at(b + 6, 5'b00001, "s3_h0_done");
    expect_at(b + 7, 5'b00000, "s3_h0_idle");

    // shortest phases, zero low treated as one
    do_reset();
    pulse_start(b + 0, 1, 0, 3);
    expect_at(b + 1, 5'b11010, "s4_c1");
    expect_at(b + 2, 5'b00110, "s4_c2");
    expect_at(b + 3, 5'b11010, "s4_c3");
    expect_at(b + 4, 5'b00110, "s4_c4");
    expect_at(b + 5, 5'b11010, "s4_c5");
    expect_at(b + 6, 5'b00110, "s4_c6");
    expect_at(b + 7, 5'b00001, "s4_done");

    // reset mid-HIGH, then reset together with start
    do_reset();
    pulse_start(b + 10, 3, 2, 2);
    go_to(b + 13);
    reset = 1;
    go_to(b + 14);
    reset = 0;
    expect_at(b + 14, 5'b00000, "s5_after_reset");
    expect_at(b + 15, 5'b00000, "s5_no_done");
    go_to(b + 20);
    reset = 1; start = 1; highCycles = 2; lowCycles = 1; pulseCount = 1;
    go_to(b + 21);
    reset = 0; start = 0;
    expect_at(b + 21, 5'b00000, "s5_reset_wins");
    expect_at(b + 22, 5'b00000, "s5_reset_wins2");

`ifdef EDGE_GENERATOR_ABORT_EN
    // abort during HIGH, then abort ignored in IDLE
    do_reset();
    pulse_start(b + 10, 3, 2, 2);
    go_to(b + 12);
    abort = 1;
    go_to(b + 13);
    abort = 0;
    expect_at(b + 13, 5'b00101, "s6_abort");
    expect_at(b + 14, 5'b00000, "s6_abort_idle");
    go_to(b + 16);
    abort = 1;
    pulse_start(b + 16, 1, 1, 1);
    abort = 0;
    expect_at(b + 17, 5'b11010, "s6_abort_idle_ignored");
`endif

    // all-ones lengths and pulse count
    do_reset();
    pulse_start(b + 2, 15, 15, 7);
    expect_at(b + 3, 5'b11010, "s7_rise1");
    expect_at(b + 17, 5'b10010, "s7_high_last");
    expect_at(b + 18, 5'b00110, "s7_fall1");
    expect_at(b + 33, 5'b11010, "s7_rise2");
    expect_at(b + 212, 5'b00010, "s7_last_low");
    expect_at(b + 213, 5'b00001, "s7_done");

    // random trains, inputs churning every cycle
    do_reset();
    nstarts = 0;
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom % 4 == 0);
      highCycles = CW'($urandom_range(0, 5));
      lowCycles = CW'($urandom_range(0, 3));
      pulseCount = NW'($urandom_range(0, 3));
      abort = ($urandom % 40 == 0);
      reset = ($urandom % 150 == 0);
      if (start && !busy && !reset && nstarts < 400) begin
        nstarts++;
        $display("[TB] cycle %0d random start H=%0d L=%0d N=%0d", cyc - b,
                 highCycles, lowCycles, pulseCount);
      end
      @(negedge clk);
    end
    start = 0; abort = 0; reset = 0;
    go_to(cyc + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
